// File: rtl/palette_pipeline.sv
// Layered palette lookup with a frame-synchronous fade-to/from-black scaler.
// Optional PAL_READBACK_EN adds a registered CPU readback port on the palette.
module palette_pipeline #(
    parameter int    IDX_W       = 6,
    parameter int    DEPTH       = 64,
    parameter int    CW          = 8,
    parameter int    LAYERS      = 4,
    parameter int    FADE_LOG2   = 3,
    parameter int    FRAMES_STEP = 2,
    parameter string PAL_INIT    = "palette.txt"
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [LAYERS*IDX_W-1:0] layer_idx,
    input  logic [IDX_W-1:0]        bg_idx,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [IDX_W-1:0]        wr_addr,
    input  logic [3*CW-1:0]         wr_rgb,
    input  logic                    fade_req,
    input  logic                    fade_dir,
    output logic                    fade_busy,
    output logic                    fade_done,
    input  logic [IDX_W-1:0]        rd_addr,
    output logic [3*CW-1:0]         rd_rgb,
    output logic                    out_valid,
    output logic [CW-1:0]           VGA_R,
    output logic [CW-1:0]           VGA_G,
    output logic [CW-1:0]           VGA_B
);

    localparam int LW    = FADE_LOG2 + 1;
    localparam int PW    = CW + LW;
    localparam int CNT_W = (FRAMES_STEP > 1) ? $clog2(FRAMES_STEP) : 1;
    localparam logic [LW-1:0]    LVL_MAX  = LW'(1 << FADE_LOG2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_STEP - 1);
    localparam logic [IDX_W:0]   DEPTH_V  = (IDX_W+1)'(DEPTH);
    localparam bit               FULL     = (DEPTH >= (1 << IDX_W));

    typedef enum logic [1:0] {BRIGHT, FADE_OUT, DARK, FADE_IN} fade_state_t;

    // The image named by PAL_INIT is attached by the FPGA build flow;
    // in simulation the palette is filled through the write port.
    logic [3*CW-1:0] pal [DEPTH];

    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] s1_sel;
    logic             s1_valid;
    logic [3*CW-1:0]  s2_rgb;
    logic             s2_valid;

    fade_state_t      state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    function automatic logic in_pal(input logic [IDX_W-1:0] a);
        return FULL || ({1'b0, a} < DEPTH_V);
    endfunction

    function automatic logic [CW-1:0] scale(input logic [CW-1:0] c,
                                            input logic [LW-1:0] l);
        logic [PW-1:0] p;
        p = PW'(c) * PW'(l);
        return p[FADE_LOG2 +: CW];
    endfunction

    assign fade_busy = (state_q == FADE_OUT) || (state_q == FADE_IN);
    assign wr_ready  = !fade_busy;
    assign fade_done = done_q;

    // Highest-priority non-transparent layer wins, else the background.
    always_comb begin
        sel = bg_idx;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            if (layer_idx[k*IDX_W +: IDX_W] != '0)
                sel = layer_idx[k*IDX_W +: IDX_W];
        end
    end

    // S1/S2: register the winner, then read the palette (old data on collision).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_sel   <= '0;
            s1_valid <= 1'b0;
            s2_rgb   <= '0;
            s2_valid <= 1'b0;
        end else begin
            s1_sel   <= sel;
            s1_valid <= pix_valid;
            s2_rgb   <= in_pal(s1_sel) ? pal[s1_sel] : '0;
            s2_valid <= s1_valid;
        end
    end

    // Palette write port; out-of-range addresses are handshaken and dropped.
    always_ff @(posedge Clk) begin
        if (wr_valid && wr_ready && in_pal(wr_addr))
            pal[wr_addr] <= wr_rgb;
    end

    // S3: scale each channel by the fade level, blank outside the active area.
    always_ff @(posedge Clk) begin
        if (Reset || !s2_valid) begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else begin
            VGA_R <= scale(s2_rgb[3*CW-1 -: CW], level_q);
            VGA_G <= scale(s2_rgb[2*CW-1 -: CW], level_q);
            VGA_B <= scale(s2_rgb[CW-1:0], level_q);
        end
    end

    // Output valid tracks the S2 valid bit.
    always_ff @(posedge Clk) begin
        if (Reset) out_valid <= 1'b0;
        else       out_valid <= s2_valid;
    end

    // Fade state, level, frame counter and done pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= BRIGHT;
            level_q <= LVL_MAX;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Fade sequencing: level moves only on frame_start to avoid tearing.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            BRIGHT: begin
                if (fade_req && !fade_dir) begin
                    state_d = FADE_OUT;
                    cnt_d   = '0;
                end
            end
            DARK: begin
                if (fade_req && fade_dir) begin
                    state_d = FADE_IN;
                    cnt_d   = '0;
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q - LW'(1);
                        if (level_q == LW'(1)) begin
                            state_d = DARK;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q + LW'(1);
                        if (level_q == LVL_MAX - LW'(1)) begin
                            state_d = BRIGHT;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef PAL_READBACK_EN
    // CPU readback: registered second read port, read-first.
    always_ff @(posedge Clk) begin
        if (Reset)                rd_rgb <= '0;
        else if (in_pal(rd_addr)) rd_rgb <= pal[rd_addr];
        else                      rd_rgb <= '0;
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_rgb    = '0;
`endif

endmodule

// File: tb/tb_palette_pipeline.sv
// Randomized self-checking bench for palette_pipeline.
// Reference model: palette array, priority rule and fade level per frame count.
module tb_palette_pipeline;

    localparam int IDX_W  = 6;
    localparam int DEPTH  = 64;
    localparam int CW     = 8;
    localparam int LAYERS = 4;

    logic                    Clk = 1'b0;
    logic                    Reset = 1'b1;
    logic                    frame_start = 1'b0;
    logic                    pix_valid = 1'b0;
    logic [LAYERS*IDX_W-1:0] layer_idx = '0;
    logic [IDX_W-1:0]        bg_idx = '0;
    logic                    wr_valid = 1'b0;
    logic                    wr_ready;
    logic [IDX_W-1:0]        wr_addr = '0;
    logic [3*CW-1:0]         wr_rgb = '0;
    logic                    fade_req = 1'b0;
    logic                    fade_dir = 1'b0;
    logic                    fade_busy;
    logic                    fade_done;
    logic [IDX_W-1:0]        rd_addr = '0;
    logic [3*CW-1:0]         rd_rgb;
    logic                    out_valid;
    logic [CW-1:0]           VGA_R, VGA_G, VGA_B;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] m_pal [DEPTH];
    int m_level = 8;

    palette_pipeline dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .pix_valid(pix_valid), .layer_idx(layer_idx), .bg_idx(bg_idx),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_rgb(wr_rgb), .fade_req(fade_req), .fade_dir(fade_dir),
        .fade_busy(fade_busy), .fade_done(fade_done), .rd_addr(rd_addr),
        .rd_rgb(rd_rgb), .out_valid(out_valid),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [24:0] dut_pix();
        return {out_valid, VGA_R, VGA_G, VGA_B};
    endfunction

    function automatic logic [23:0] fade_rgb(input logic [23:0] c, input int lvl);
        int r, g, b;
        r = (int'(c[23:16]) * lvl) / 8;
        g = (int'(c[15:8]) * lvl) / 8;
        b = (int'(c[7:0]) * lvl) / 8;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic logic [24:0] ref_pix(input logic [LAYERS*IDX_W-1:0] ly,
                                            input logic [IDX_W-1:0] bg,
                                            input logic v, input int lvl);
        int idx;
        bit found;
        idx = int'(bg);
        found = 0;
        for (int k = 0; k < LAYERS; k++) begin
            if (!found && ly[k*IDX_W +: IDX_W] != 0) begin
                idx = int'(ly[k*IDX_W +: IDX_W]);
                found = 1;
            end
        end
        if (!v) return '0;
        return {1'b1, fade_rgb(m_pal[idx], lvl)};
    endfunction

    function automatic logic [LAYERS*IDX_W-1:0] rand_layers();
        logic [LAYERS*IDX_W-1:0] ly;
        ly = '0;
        for (int k = 0; k < LAYERS; k++)
            if ($urandom_range(0, 1) == 1)
                ly[k*IDX_W +: IDX_W] = IDX_W'($urandom_range(1, 63));
        return ly;
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        pix_valid = 1'b1;
        layer_idx = rand_layers();
        tick();
        tick();
        n_cmp++;
        if (dut_pix() !== 25'd0) begin
            n_err++;
            $display("FAIL reset_pix got=%h exp=0", dut_pix());
        end
        n_cmp++;
        if ({wr_ready, fade_busy, fade_done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_ctl got=%b exp=100", {wr_ready, fade_busy, fade_done});
        end
        n_cmp++;
        if (rd_rgb !== 24'd0) begin
            n_err++;
            $display("FAIL reset_rd got=%h exp=0", rd_rgb);
        end
        Reset = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic load_palette();
        for (int a = 0; a < DEPTH; a++) begin
            m_pal[a] = (a == 7) ? 24'hFFFFFF : 24'($urandom);
            wr_valid = 1'b1;
            wr_addr = IDX_W'(a);
            wr_rgb = m_pal[a];
            n_cmp++;
            if (wr_ready !== 1'b1) begin
                n_err++;
                $display("FAIL load_ready addr=%0d got=%b exp=1", a, wr_ready);
            end
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_priority();
        logic [24:0] q[$];
        logic [24:0] exp;
        for (int i = 0; i < 203; i++) begin
            if (i == 0) begin
                layer_idx = {6'd0, 6'd9, 6'd5, 6'd0};
                bg_idx = 6'd2;
                pix_valid = 1'b1;
            end else if (i == 1) begin
                layer_idx = '0;
                bg_idx = 6'd2;
                pix_valid = 1'b1;
            end else if (i == 2) begin
                layer_idx = rand_layers();
                pix_valid = 1'b0;
            end else begin
                layer_idx = rand_layers();
                bg_idx = IDX_W'($urandom_range(0, 63));
                pix_valid = ($urandom_range(0, 9) != 0);
            end
            q.push_back(ref_pix(layer_idx, bg_idx, pix_valid, m_level));
            tick();
            if (q.size() == 3) begin
                exp = q.pop_front();
                n_cmp++;
                if (dut_pix() !== exp) begin
                    n_err++;
                    $display("FAIL priority i=%0d got=%h exp=%h", i, dut_pix(), exp);
                end
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_write();
        logic [23:0] old;
        old = m_pal[5];
        layer_idx = '0;
        bg_idx = 6'd5;
        pix_valid = 1'b1;
        tick();
        wr_valid = 1'b1;
        wr_addr = 6'd5;
        wr_rgb = 24'h123456;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL write_ready got=%b exp=1", wr_ready);
        end
        tick();
        m_pal[5] = 24'h123456;
        wr_valid = 1'b0;
        pix_valid = 1'b0;
        rd_addr = 6'd5;
        tick();
        n_cmp++;
        if (dut_pix() !== {1'b1, old}) begin
            n_err++;
            $display("FAIL write_readfirst got=%h exp=%h", dut_pix(), {1'b1, old});
        end
        n_cmp++;
`ifdef PAL_READBACK_EN
        if (rd_rgb !== 24'h123456) begin
            n_err++;
            $display("FAIL readback got=%h exp=123456", rd_rgb);
        end
`else
        if (rd_rgb !== 24'h0) begin
            n_err++;
            $display("FAIL readback_off got=%h exp=0", rd_rgb);
        end
`endif
        tick();
        n_cmp++;
        if (dut_pix() !== {1'b1, 24'h123456}) begin
            n_err++;
            $display("FAIL write_new got=%h exp=1123456", dut_pix());
        end
    endtask

    task automatic run_fade(input bit dir, input int frames);
        logic [24:0] exp;
        int lvl;
        bit last;
        layer_idx = 24'd7;
        pix_valid = 1'b1;
        fade_req = 1'b1;
        fade_dir = dir;
        frame_start = 1'b1;
        tick();
        fade_req = 1'b0;
        frame_start = 1'b0;
        n_cmp++;
        if ({fade_busy, fade_done, wr_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL fade_start dir=%0d got=%b exp=100", dir, {fade_busy, fade_done, wr_ready});
        end
        for (int k = 1; k <= frames; k++) begin
            last = (k == 16);
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            n_cmp++;
            if ({fade_busy, fade_done} !== {!last, last}) begin
                n_err++;
                $display("FAIL fade_edge dir=%0d k=%0d got=%b exp=%b", dir, k, {fade_busy, fade_done}, {!last, last});
            end
            if (k == 6) begin
                fade_req = 1'b1;
                fade_dir = !dir;
                wr_valid = 1'b1;
                wr_addr = 6'd7;
                wr_rgb = 24'h0;
            end
            tick();
            fade_req = 1'b0;
            wr_valid = 1'b0;
            tick();
            tick();
            tick();
            lvl = dir ? k / 2 : 8 - k / 2;
            exp = {1'b1, fade_rgb(m_pal[7], lvl)};
            n_cmp++;
            if (dut_pix() !== exp) begin
                n_err++;
                $display("FAIL fade_level dir=%0d k=%0d got=%h exp=%h", dir, k, dut_pix(), exp);
            end
            n_cmp++;
            if ({wr_ready, fade_done} !== {last, 1'b0}) begin
                n_err++;
                $display("FAIL fade_hold dir=%0d k=%0d got=%b exp=%b", dir, k, {wr_ready, fade_done}, {last, 1'b0});
            end
        end
        m_level = dir ? frames / 2 : 8 - frames / 2;
    endtask

    task automatic test_ignored_req(input bit dir);
        fade_req = 1'b1;
        fade_dir = dir;
        tick();
        fade_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({fade_busy, fade_done} !== 2'b00) begin
                n_err++;
                $display("FAIL ignored_req dir=%0d i=%0d got=%b exp=00", dir, i, {fade_busy, fade_done});
            end
            tick();
        end
    endtask

    task automatic test_fade_out();
        run_fade(1'b0, 16);
        test_ignored_req(1'b0);
    endtask

    task automatic test_fade_in();
        run_fade(1'b1, 16);
        n_cmp++;
        if (dut_pix() !== {1'b1, 24'hFFFFFF}) begin
            n_err++;
            $display("FAIL fade_in_end got=%h exp=1ffffff", dut_pix());
        end
        test_ignored_req(1'b1);
    endtask

    task automatic test_reset_mid_fade();
        run_fade(1'b0, 8);
        n_cmp++;
        if (dut_pix() !== {1'b1, 24'h7F7F7F}) begin
            n_err++;
            $display("FAIL mid_level got=%h exp=17f7f7f", dut_pix());
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_level = 8;
        n_cmp++;
        if ({fade_busy, wr_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_reset_ctl got=%b exp=01", {fade_busy, wr_ready});
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (dut_pix() !== 25'd0) begin
                n_err++;
                $display("FAIL mid_reset_flush i=%0d got=%h exp=0", i, dut_pix());
            end
            tick();
        end
        n_cmp++;
        if (dut_pix() !== {1'b1, 24'hFFFFFF}) begin
            n_err++;
            $display("FAIL mid_reset_refill got=%h exp=1ffffff", dut_pix());
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        load_palette();
        test_priority();
        test_write();
        test_fade_out();
        test_fade_in();
        test_reset_mid_fade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
